// File: rtl/systolic_pkg.sv
// Shared types for the systolic-array scheduler / result collector pair.
// Holds the default array geometry, the row-index width, the result word type
// and the collector FSM state encoding.
package systolic_pkg;

    localparam int unsigned DEF_MATRIX_SIZE = 2;
    localparam int unsigned DEF_DATA_SIZE   = 32;
    localparam int unsigned IDX_W           = $clog2(DEF_MATRIX_SIZE);

    typedef logic [DEF_DATA_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } collector_state_t;

endpackage

// File: rtl/result_row_buffer.sv
// N x N result word storage for the collector.
// Ports:
//   clk      rising-edge clock
//   wr_en    per-column write enable
//   wr_row   per-column row address, column j at [j*ROW_W +: ROW_W]
//   wr_data  per-column write word, column j at [j*DATA_SIZE +: DATA_SIZE]
//   rd_row   row address for the full-row read port
//   rd_data  combinational full-row read, column j at [j*DATA_SIZE +: DATA_SIZE]
module result_row_buffer #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32
) (
    input  logic                                 clk,
    input  logic [MATRIX_SIZE-1:0]               wr_en,
    input  logic [MATRIX_SIZE*$clog2(MATRIX_SIZE)-1:0] wr_row,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]     wr_data,
    input  logic [$clog2(MATRIX_SIZE)-1:0]       rd_row,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]     rd_data
);

    localparam int unsigned ROW_W = $clog2(MATRIX_SIZE);

    // mem[row][col]; no reset, validity is tracked by the collector
    logic [DATA_SIZE-1:0] mem [MATRIX_SIZE][MATRIX_SIZE];

    // Independent column write ports
    always_ff @(posedge clk) begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            if (wr_en[j]) begin
                mem[wr_row[j*ROW_W +: ROW_W]][j] <= wr_data[j*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Full-row read port
    always_comb begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            rd_data[j*DATA_SIZE +: DATA_SIZE] = mem[rd_row][j];
        end
    end

endmodule

// File: rtl/result_collector.sv
// Deskews per-column results leaving the PE array into complete rows and
// delivers them in order over valid/ready, pulsing done after the last row.
// Optional feature: define RESULT_COLLECTOR_RELU_EN to clamp negative words
// on out_row to zero (buffer keeps raw values).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         pulse that arms collection of one matrix
//   col_valid     per-column word valid
//   col_data      per-column words, column j at [j*DATA_SIZE +: DATA_SIZE]
//   out_valid     out_row holds a complete row
//   out_ready     consumer accepts row
//   out_row       row data, column j at [j*DATA_SIZE +: DATA_SIZE]
//   out_row_idx   index of the presented row
//   busy          collector not idle
//   done          one-cycle pulse after the last row is accepted
//   error         sticky protocol-violation flag
module result_collector
    import systolic_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int unsigned DATA_SIZE   = DEF_DATA_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [MATRIX_SIZE-1:0]           col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_row,
    output logic [$clog2(MATRIX_SIZE)-1:0]   out_row_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int unsigned ROW_W    = $clog2(MATRIX_SIZE);
    localparam int unsigned PTR_W    = ROW_W + 1;
    localparam int unsigned ROW_BITS = MATRIX_SIZE * DATA_SIZE;

    collector_state_t         state, state_d;
    logic [PTR_W-1:0]         wr_ptr   [MATRIX_SIZE];
    logic [PTR_W-1:0]         wr_ptr_d [MATRIX_SIZE];
    logic [ROW_W-1:0]         rd_ptr, rd_ptr_d;
    logic [MATRIX_SIZE-1:0]   row_complete, row_complete_d;
    logic                     error_d;
    logic                     out_valid_d;
    logic                     handshake;
    logic [MATRIX_SIZE-1:0]   wr_en;
    logic [MATRIX_SIZE*ROW_W-1:0] wr_row;
    logic [ROW_BITS-1:0]      rd_data;
    logic [ROW_BITS-1:0]      out_row_d;

    // Column j always writes at its own pointer; overflow is masked by wr_en
    always_comb begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            wr_row[j*ROW_W +: ROW_W] = wr_ptr[j][ROW_W-1:0];
        end
    end

    // Reads follow the next read pointer so out_row is registered together with out_valid
    result_row_buffer #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (col_data),
        .rd_row  (rd_ptr_d),
        .rd_data (rd_data)
    );

    // Read-path word shaping
    always_comb begin
        out_row_d = rd_data;
`ifdef RESULT_COLLECTOR_RELU_EN
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            if (rd_data[j*DATA_SIZE + DATA_SIZE - 1]) begin
                out_row_d[j*DATA_SIZE +: DATA_SIZE] = '0;
            end
        end
`endif
    end

    // Next-state, pointer and error logic
    always_comb begin
        state_d        = state;
        rd_ptr_d       = rd_ptr;
        row_complete_d = row_complete;
        error_d        = error;
        wr_en          = '0;
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            wr_ptr_d[j] = wr_ptr[j];
        end
        handshake = out_valid & out_ready;

        case (state)
            ST_IDLE: begin
                if (|col_valid) begin
                    error_d = 1'b1;
                end
                if (start) begin
                    state_d        = ST_ACTIVE;
                    rd_ptr_d       = '0;
                    row_complete_d = '0;
                    for (int j = 0; j < MATRIX_SIZE; j++) begin
                        wr_ptr_d[j] = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (start) begin
                    error_d = 1'b1;
                end
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    if (col_valid[j]) begin
                        if (wr_ptr[j] == PTR_W'(MATRIX_SIZE)) begin
                            error_d = 1'b1;
                        end else begin
                            wr_en[j]    = 1'b1;
                            wr_ptr_d[j] = wr_ptr[j] + PTR_W'(1);
                        end
                    end
                end
                // A row is complete once every column has written past it
                for (int r = 0; r < MATRIX_SIZE; r++) begin
                    row_complete_d[r] = 1'b1;
                    for (int j = 0; j < MATRIX_SIZE; j++) begin
                        if (wr_ptr[j] <= PTR_W'(r)) begin
                            row_complete_d[r] = 1'b0;
                        end
                    end
                end
                if (handshake) begin
                    if (rd_ptr == ROW_W'(MATRIX_SIZE - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr + ROW_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (start || (|col_valid)) begin
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_ACTIVE) && row_complete_d[rd_ptr_d];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rd_ptr       <= '0;
            row_complete <= '0;
            error        <= 1'b0;
            out_valid    <= 1'b0;
            out_row      <= '0;
            out_row_idx  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                wr_ptr[j] <= '0;
            end
        end else begin
            state        <= state_d;
            rd_ptr       <= rd_ptr_d;
            row_complete <= row_complete_d;
            error        <= error_d;
            out_valid    <= out_valid_d;
            out_row_idx  <= rd_ptr_d;
            busy         <= (state_d != ST_IDLE);
            done         <= (state_d == ST_DONE);
            if (out_valid_d) begin
                out_row <= out_row_d;
            end
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                wr_ptr[j] <= wr_ptr_d[j];
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector (N=2, 32-bit words).
module tb_result_collector;
    import systolic_pkg::*;

    localparam int unsigned N = DEF_MATRIX_SIZE;
    localparam int unsigned W = DEF_DATA_SIZE;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N-1:0]      col_valid;
    logic [N*W-1:0]    col_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*W-1:0]    out_row;
    logic [IDX_W-1:0]  out_row_idx;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .col_valid   (col_valid),
        .col_data    (col_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    typedef struct {
        logic [63:0] idx;
        logic [63:0] row;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          d0;
    logic        hold     = 1'b0;
    logic [63:0] held_row;
    logic [63:0] held_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] shape(input logic [31:0] w);
`ifdef RESULT_COLLECTOR_RELU_EN
        return w[31] ? 32'd0 : w;
`else
        return w;
`endif
    endfunction

    task automatic push(input int idx, input logic [31:0] c0, input logic [31:0] c1);
        exp_t x;
        x.idx = 64'(idx);
        x.row = {shape(c1), shape(c0)};
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] c0, input logic [31:0] c1);
        col_valid = v;
        col_data  = {c1, c0};
        step();
        col_valid = '0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // Monitor: pops expected rows on each accepted row and checks hold stability
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (hold) begin
                check("held_valid", 64'(out_valid), 64'd1);
                check("held_row", out_row, held_row);
                check("held_idx", 64'(out_row_idx), held_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("row_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", out_row, e.row);
                    check("row_idx", 64'(out_row_idx), e.idx);
                end
            end
            hold     = out_valid && !out_ready;
            held_row = out_row;
            held_idx = 64'(out_row_idx);
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        col_valid = 2'b11;
        col_data  = {32'hDEAD_BEEF, 32'h1234_5678};

        // Reset with col_valid active
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_out_row", out_row, 64'd0);
        check("rst_idx", 64'(out_row_idx), 64'd0);
        reset     = 1'b0;
        col_valid = '0;

        // Skewed matrix, consumer always ready
        out_ready = 1'b1;
        push(0, 32'd10, 32'd11);
        push(1, 32'd20, 32'd21);
        start = 1'b1;
        step();
        start = 1'b0;
        check("skew_busy", 64'(busy), 64'd1);
        drive(2'b01, 32'd10, 32'd0);
        drive(2'b11, 32'd20, 32'd11);
        check("skew_row0_not_yet", 64'(out_valid), 64'd0);
        drive(2'b10, 32'd0, 32'd21);
        check("skew_row0_valid", 64'(out_valid), 64'd1);
        check("skew_row0_idx", 64'(out_row_idx), 64'd0);
        step();
        check("skew_row1_valid", 64'(out_valid), 64'd1);
        check("skew_row1_idx", 64'(out_row_idx), 64'd1);
        step();
        check("skew_done", 64'(done), 64'd1);
        check("skew_busy_in_done", 64'(busy), 64'd1);
        check("skew_valid_in_done", 64'(out_valid), 64'd0);
        step();
        check("skew_done_clear", 64'(done), 64'd0);
        check("skew_idle", 64'(busy), 64'd0);
        check("skew_drained", 64'(exp_q.size()), 64'd0);
        check("skew_no_error", 64'(error), 64'd0);

        // Backpressure until edge 8
        d0 = done_cnt;
        out_ready = 1'b0;
        push(0, 32'd10, 32'd11);
        push(1, 32'd20, 32'd21);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(2'b01, 32'd10, 32'd0);
        drive(2'b11, 32'd20, 32'd11);
        drive(2'b10, 32'd0, 32'd21);
        for (int k = 4; k <= 7; k++) begin
            step();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_idx", 64'(out_row_idx), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_row1_valid", 64'(out_valid), 64'd1);
        check("bp_row1_idx", 64'(out_row_idx), 64'd1);
        step();
        check("bp_done", 64'(done), 64'd1);
        step();
        check("bp_idle", 64'(busy), 64'd0);
        check("bp_single_done", 64'(done_cnt - d0), 64'd1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Overflow and start-while-busy
        out_ready = 1'b0;
        push(0, 32'd10, 32'd11);
        push(1, 32'd20, 32'd21);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(2'b01, 32'd10, 32'd0);
        drive(2'b11, 32'd20, 32'd11);
        drive(2'b10, 32'd0, 32'd21);
        check("ovf_no_error_yet", 64'(error), 64'd0);
        drive(2'b01, 32'd99, 32'd0);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_row_kept", out_row, {32'd11, 32'd10});
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy_error", 64'(error), 64'd1);
        check("start_busy_still_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        wait_done("ovf_done");
        step();
        check("ovf_error_sticky", 64'(error), 64'd1);
        check("ovf_idle", 64'(busy), 64'd0);
        check("ovf_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation, then a fresh matrix
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        drive(2'b11, 32'd10, 32'd11);
        step();
        check("mid_row0_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_error_cleared", 64'(error), 64'd0);
        check("mid_out_row", out_row, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        push(0, 32'd3, 32'd4);
        push(1, 32'd5, 32'd6);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(2'b11, 32'd3, 32'd4);
        drive(2'b11, 32'd5, 32'd6);
        wait_done("mid_fresh_done");
        step();
        check("mid_drained", 64'(exp_q.size()), 64'd0);

        // Negative words on the read path
        push(0, 32'hFFFF_FFF6, 32'd5);
        push(1, 32'd7, 32'hFFFF_FF80);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(2'b11, 32'hFFFF_FFF6, 32'd5);
        drive(2'b11, 32'd7, 32'hFFFF_FF80);
        wait_done("relu_done");
        step();
        check("relu_drained", 64'(exp_q.size()), 64'd0);
        check("relu_no_error", 64'(error), 64'd0);

        // col_valid while idle, cleared only by reset
        drive(2'b01, 32'd1, 32'd0);
        check("idle_col_error", 64'(error), 64'd1);
        step();
        check("idle_error_sticky", 64'(error), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("error_reset", 64'(error), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
